// File: rtl/updi_pkg.sv
// Shared UPDI definitions: transmitter state encoding and frame constants.
package updi_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY, STOP, BREAK, BREAK_STOP
  } updi_tx_state;

  localparam int UPDI_STOP_BITS = 2;
  localparam int UPDI_DATA_BITS = 8;

  // Even parity bit: makes the total count of ones (data + parity) even.
  function automatic logic updi_even_par(input logic [UPDI_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/updi_baud_gen.sv
// Bit-time generator: counts 0..CLK_DIV-1 and flags the last clock of each bit.
module updi_baud_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_done,
  output logic bit_near
);
  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  // bit_done marks the last clock of a bit; bit_near the clock before it,
  // so the parent can register outputs that line up with bit_done.
  assign bit_done = (cnt == CW'(CLK_DIV - 1));
  assign bit_near = (cnt == CW'(CLK_DIV - 2));

  // Free-running bit counter, cleared on restart (state entry) and at wrap.
  always_ff @(posedge clk) begin
    if (!rst_n || restart) cnt <= '0;
    else if (bit_done)     cnt <= '0;
    else                   cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/updi_tx_serializer.sv
// UPDI transmitter: pops bytes from the handler FIFO and sends 8E2 UART
// frames, or BREAK conditions on request. All outputs are registered from
// the next-state decode so they change exactly on state boundaries.
module updi_tx_serializer
  import updi_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int BREAK_BITS = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic       send_break,
  output logic       tx,
  output logic       tx_en,
  output logic       busy,
  output logic       byte_sent
);
  // One counter serves data bits, stop bits and break bits.
  localparam int BW = (BREAK_BITS > UPDI_DATA_BITS) ? $clog2(BREAK_BITS) : 3;

  updi_tx_state state, state_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic [7:0]    data_q;
  logic          par_q;
  logic          load;
  logic          tx_nxt, tx_en_nxt, rd_nxt, sent_nxt, busy_nxt;
  logic          bit_done, bit_near, restart;

  // Restart the bit timer on every state change so each state gets full bits.
  assign restart = (state_nxt != state);

  updi_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (restart),
    .bit_done (bit_done),
    .bit_near (bit_near)
  );

  // Next-state, bit counting and registered-output decode.
  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    rd_nxt    = 1'b0;
    sent_nxt  = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (send_break) begin
          state_nxt = BREAK;
          bit_nxt   = '0;
        end else if (!fifo_empty) begin
          state_nxt = FETCH;
          rd_nxt    = 1'b1;
        end
      end
      FETCH: state_nxt = LOAD;
      LOAD: begin
        load      = 1'b1;
        state_nxt = START;
      end
      START: if (bit_done) begin
        state_nxt = DATA;
        bit_nxt   = '0;
      end
      DATA: if (bit_done) begin
        if (bit_cnt == BW'(UPDI_DATA_BITS - 1)) state_nxt = PARITY;
        else                                    bit_nxt   = bit_cnt + BW'(1);
      end
      PARITY: if (bit_done) begin
        state_nxt = STOP;
        bit_nxt   = '0;
      end
      STOP: begin
        // Registered one clock early so the pulse lands on the final stop clock.
        sent_nxt = (bit_cnt == BW'(UPDI_STOP_BITS - 1)) && bit_near;
        if (bit_done) begin
          if (bit_cnt == BW'(UPDI_STOP_BITS - 1)) state_nxt = IDLE;
          else                                    bit_nxt   = bit_cnt + BW'(1);
        end
      end
      BREAK: if (bit_done) begin
        if (bit_cnt == BW'(BREAK_BITS - 1)) begin
          state_nxt = BREAK_STOP;
          bit_nxt   = '0;
        end else begin
          bit_nxt = bit_cnt + BW'(1);
        end
      end
      BREAK_STOP: if (bit_done) begin
        if (bit_cnt == BW'(UPDI_STOP_BITS - 1)) state_nxt = IDLE;
        else                                    bit_nxt   = bit_cnt + BW'(1);
      end
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      START, BREAK: tx_nxt = 1'b0;
      DATA:         tx_nxt = data_q[bit_nxt[2:0]];
      PARITY:       tx_nxt = par_q;
      default:      tx_nxt = 1'b1;
    endcase
    tx_en_nxt = state_nxt inside {START, DATA, PARITY, STOP, BREAK, BREAK_STOP};
    busy_nxt  = (state_nxt != IDLE);
  end

  // State, frame data and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      tx         <= 1'b1;
      tx_en      <= 1'b0;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      byte_sent  <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_nxt;
      if (load) begin
        data_q <= fifo_data;
        par_q  <= updi_even_par(fifo_data);
      end
      tx         <= tx_nxt;
      tx_en      <= tx_en_nxt;
      fifo_rd_en <= rd_nxt;
      busy       <= busy_nxt;
      byte_sent  <= sent_nxt;
    end
  end

endmodule

// File: tb/tb_updi_tx_serializer.sv
// Bench for updi_tx_serializer: FIFO model plus a waveform reference built
// from frame rules (start, LSB-first data, even parity, two stops, gaps).
module tb_updi_tx_serializer;
  localparam int CLK_DIV    = 4;
  localparam int BREAK_BITS = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       send_break = 1'b0;
  logic       fifo_rd_en, tx, tx_en, busy, byte_sent;

  updi_tx_serializer #(.CLK_DIV(CLK_DIV), .BREAK_BITS(BREAK_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .send_break(send_break), .tx(tx), .tx_en(tx_en),
    .busy(busy), .byte_sent(byte_sent)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic tx; logic en; logic sent; logic busy; } exp_t;

  int         checks = 0, errors = 0;
  logic [7:0] fq[$];
  logic [7:0] sq[$];
  exp_t       exq[$];
  logic       pend = 1'b0;
  logic [7:0] pend_d = 8'h00;
  int         rd_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; FIFO data is only valid in the cycle after a pop, else junk.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pend) begin
      fifo_data = pend_d;
      pend      = 1'b0;
    end else begin
      fifo_data = 8'($urandom);
    end
    if (fifo_rd_en) begin
      rd_cnt++;
      chk("rd_nonempty", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) begin
        pend_d = fq.pop_front();
        pend   = 1'b1;
      end
    end
    fifo_empty = (fq.size() == 0);
  endtask

  function automatic void add_frame(input logic [7:0] d);
    logic bv;
    for (int k = 0; k < 12; k++) begin
      if (k == 0)     bv = 1'b0;
      else if (k < 9) bv = d[k-1];
      else if (k == 9) bv = (($countones(d) % 2) == 1);
      else            bv = 1'b1;
      for (int c = 0; c < CLK_DIV; c++)
        exq.push_back('{tx: bv, en: 1'b1, sent: (k == 11 && c == CLK_DIV-1), busy: 1'b1});
    end
  endfunction

  function automatic void add_break();
    for (int c = 0; c < (BREAK_BITS + 2) * CLK_DIV; c++)
      exq.push_back('{tx: (c >= BREAK_BITS * CLK_DIV), en: 1'b1, sent: 1'b0, busy: 1'b1});
  endfunction

  // Idle clock(s) between frames: first is IDLE (not busy), rest are fetch.
  function automatic void add_gap(input int n);
    for (int c = 0; c < n; c++)
      exq.push_back('{tx: 1'b1, en: 1'b0, sent: 1'b0, busy: (c != 0)});
  endfunction

  // Sends the bytes in sq, optionally preceded by a break (brk) or followed by
  // a break requested mid-frame (mid), and checks the whole line waveform.
  task automatic run(input bit brk, input bit mid);
    int n, bstart;
    exq.delete();
    rd_cnt = 0;
    if (brk) add_break();
    foreach (sq[i]) begin
      if (i > 0 || brk) add_gap(3);
      add_frame(sq[i]);
    end
    bstart = exq.size() + 1;
    if (mid) begin
      add_gap(1);
      add_break();
    end
    foreach (sq[i]) fq.push_back(sq[i]);
    fifo_empty = (fq.size() == 0);
    send_break = brk;
    n = 0;
    do begin
      tick();
      n++;
    end while (!tx_en && n < 20);
    chk("latency", 32'(n), brk ? 32'd1 : 32'd3);
    send_break = 1'b0;
    for (int i = 0; i < exq.size(); i++) begin
      if (i > 0) tick();
      chk($sformatf("wave%0d", i), 32'({tx, tx_en, byte_sent, busy}), 32'(exq[i]));
      if (mid && i == 10) send_break = 1'b1;
      if (mid && i == bstart) send_break = 1'b0;
    end
    repeat (6) begin
      tick();
      chk("idle_after", 32'({tx, tx_en, busy, fifo_rd_en}), 32'b1000);
    end
    chk("rd_count", 32'(rd_cnt), 32'(sq.size()));
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sent", 32'(byte_sent), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    sq = '{8'h55};              run(1'b0, 1'b0);
    sq = '{8'h01};              run(1'b0, 1'b0);
    sq = '{8'h00};              run(1'b0, 1'b0);
    sq = '{8'h55, 8'hC4, 8'h1F}; run(1'b0, 1'b0);
    sq = '{8'h55};              run(1'b1, 1'b0);
    sq = '{8'hA3};              run(1'b0, 1'b1);
    sq.delete();                run(1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      sq.delete();
      for (int b = 0; b < int'($urandom_range(1, 3)); b++) sq.push_back(8'($urandom));
      run(1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset during data bit 3 of a frame; the popped byte is dropped.
    sq = '{8'h55};
    fq.push_back(8'h55);
    fifo_empty = 1'b0;
    begin
      int n;
      n = 0;
      do begin
        tick();
        n++;
      end while (!tx_en && n < 20);
      chk("rst_lat", 32'(n), 32'd3);
    end
    repeat (17) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_out", 32'({tx, tx_en, busy}), 32'b100);
    rst_n = 1'b1;
    fq.delete();
    pend = 1'b0;
    fifo_empty = 1'b1;
    repeat (8) begin
      tick();
      chk("postrst_idle", 32'({tx, tx_en, busy, fifo_rd_en}), 32'b1000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
